// File: rtl/sync_width_conv_fifo_pkg.sv
// Shared helpers for the width-converting FIFO family.
// Provides width math (min/max/ratio), lane counts per access and
// a parameter legality function used to reject illegal builds at elaboration.
package fifo_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int min_w(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int max_w(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   function automatic int ratio_of(input int w_in, input int w_out);
      return max_w(w_in, w_out) / min_w(w_in, w_out);
   endfunction

   // Units consumed by one write: wide writes split into several units
   function automatic int w_units_of(input int w_in, input int w_out);
      return (w_in > w_out) ? ratio_of(w_in, w_out) : 1;
   endfunction

   // Units produced by one read: wide reads gather several units
   function automatic int r_units_of(input int w_in, input int w_out);
      return (w_out > w_in) ? ratio_of(w_in, w_out) : 1;
   endfunction

   // Ratio must be 2^k with k in 0..3, depth a power of two holding two wide words
   function automatic bit params_ok(input int w_in, input int w_out, input int depth);
      int r;
      r = ratio_of(w_in, w_out);
      return (max_w(w_in, w_out) % min_w(w_in, w_out) == 0) && is_pow2(r) && (r <= 8)
             && is_pow2(depth) && (depth >= 2 * r);
   endfunction

endpackage

// File: rtl/sync_width_conv_fifo_if.sv
// Handshake/data bundle between a producer/consumer pair and the FIFO.
// The FIFO takes the slave view; the surrounding logic takes the master view.
// Count is sized to hold the full depth (one extra bit over the pointers).
interface sync_width_conv_fifo_if
   import fifo_pkg::*;
#(
   parameter int DATA_WRITE_IN  = 64,
   parameter int DATA_WRITE_OUT = 16,
   parameter int DEPTH_UNITS    = 32
) ();
   localparam int PTR_W = clog2(DEPTH_UNITS);

   logic                      wr_en;
   logic [DATA_WRITE_IN-1:0]  d;
   logic                      rd_en;
   logic [DATA_WRITE_OUT-1:0] q;
   logic                      q_valid;
   logic                      full;
   logic                      empty;
   logic                      almost_full;
   logic [PTR_W:0]            count;
   logic                      ovf;
   logic                      udf;

   modport master (
      output wr_en, d, rd_en,
      input  q, q_valid, full, empty, almost_full, count, ovf, udf
   );

   modport slave (
      input  wr_en, d, rd_en,
      output q, q_valid, full, empty, almost_full, count, ovf, udf
   );
endinterface

// File: rtl/sync_width_conv_fifo_ram.sv
// Unit-organised simple dual-port RAM with multi-lane write and read ports.
// Latency: writes land at the clock edge; read data is registered (1 cycle).
// No backpressure: the caller guarantees lanes address free/stored units only.
module sync_unit_ram
   import fifo_pkg::*;
#(
   parameter int UNIT_W  = 16,
   parameter int DEPTH   = 32,
   parameter int W_LANES = 4,
   parameter int R_LANES = 1,
   localparam int PTR_W  = clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [W_LANES-1:0]          we,
   input  logic [PTR_W-1:0]            waddr,
   input  logic [W_LANES*UNIT_W-1:0]   wdata,
   input  logic                        re,
   input  logic [PTR_W-1:0]            raddr,
   output logic [R_LANES*UNIT_W-1:0]   rdata
);
   logic [UNIT_W-1:0] mem [DEPTH];

   // Write each enabled lane i to waddr+i; the address wraps at the pointer width
   always_ff @(posedge clk) begin
      for (int i = 0; i < W_LANES; i++) begin
         if (we[i]) mem[waddr + PTR_W'(i)] <= wdata[i*UNIT_W +: UNIT_W];
      end
   end

   // Registered read of R_LANES units from raddr upward; holds its value when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         for (int i = 0; i < R_LANES; i++) begin
            rdata[i*UNIT_W +: UNIT_W] <= mem[raddr + PTR_W'(i)];
         end
      end
   end
endmodule

// File: rtl/sync_width_conv_fifo.sv
// Single-clock FIFO converting between power-of-two related write/read widths.
// Latency: write visible in count after 1 edge; read data/q_valid 1 cycle after accept.
// Backpressure: full/empty decoded from the count register; refused requests set sticky ovf/udf.
module sync_width_conv_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WRITE_IN  = 64,
   parameter int DATA_WRITE_OUT = 16,
   parameter int DEPTH_UNITS    = 32,
   parameter int AF_LEVEL       = DEPTH_UNITS - 4
) (
   input  logic                   clk,
   input  logic                   rst,
   sync_width_conv_fifo_if.slave  bus
);
   localparam int UNIT_W  = min_w(DATA_WRITE_IN, DATA_WRITE_OUT);
   localparam int W_UNITS = w_units_of(DATA_WRITE_IN, DATA_WRITE_OUT);
   localparam int R_UNITS = r_units_of(DATA_WRITE_IN, DATA_WRITE_OUT);
   localparam int PTR_W   = clog2(DEPTH_UNITS);

   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH_UNITS);
   localparam logic [PTR_W:0] W_C     = (PTR_W+1)'(W_UNITS);
   localparam logic [PTR_W:0] R_C     = (PTR_W+1)'(R_UNITS);
   localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_LEVEL);

   if (!params_ok(DATA_WRITE_IN, DATA_WRITE_OUT, DEPTH_UNITS)) begin : g_bad_params
      $fatal(1, "sync_width_conv_fifo: width ratio or depth is not a legal power of two");
   end

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   free_units;
   logic             full;
   logic             empty;
   logic             wr_acc;
   logic             rd_acc;
   logic             q_valid_r;
   logic             ovf_r;
   logic             udf_r;
   logic [DATA_WRITE_OUT-1:0] rdata;

   // Flags come only from the registered count, never from same-cycle requests
   always_comb begin
      free_units = DEPTH_C - count_r;
      full       = free_units < W_C;
      empty      = count_r < R_C;
      wr_acc     = bus.wr_en & ~full & ~rst;
      rd_acc     = bus.rd_en & ~empty & ~rst;
   end

   // Pointers, occupancy, read-valid pulse and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_r   <= '0;
         q_valid_r <= 1'b0;
         ovf_r     <= 1'b0;
         udf_r     <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + W_C[PTR_W-1:0];
         if (rd_acc) rd_ptr <= rd_ptr + R_C[PTR_W-1:0];
         count_r   <= count_r + (wr_acc ? W_C : '0) - (rd_acc ? R_C : '0);
         q_valid_r <= rd_acc;
         if (bus.wr_en && full)  ovf_r <= 1'b1;
         if (bus.rd_en && empty) udf_r <= 1'b1;
      end
   end

   // Unit lane i of the write word is d[i*UNIT_W +: UNIT_W]; lane 0 lands at wr_ptr,
   // and read lane 0 (oldest unit) fills the LSBs of q, giving little-endian order.
   sync_unit_ram #(
      .UNIT_W  (UNIT_W),
      .DEPTH   (DEPTH_UNITS),
      .W_LANES (W_UNITS),
      .R_LANES (R_UNITS)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    ({W_UNITS{wr_acc}}),
      .waddr (wr_ptr),
      .wdata (bus.d),
      .re    (rd_acc),
      .raddr (rd_ptr),
      .rdata (rdata)
   );

   assign bus.q           = rdata;
   assign bus.q_valid     = q_valid_r;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = count_r >= AF_C;
   assign bus.count       = count_r;
   assign bus.ovf         = ovf_r;
   assign bus.udf         = udf_r;
endmodule

// File: tb/tb_sync_width_conv_fifo.sv
// Bench for sync_width_conv_fifo: one narrowing (64->16) and one widening (16->64) instance.
// A queue-of-units reference model predicts every output after each clock edge.
// Directed scenarios are followed by a randomized phase, then a mid-traffic reset.
module tb_sync_width_conv_fifo;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   sync_width_conv_fifo_if #(.DATA_WRITE_IN(64), .DATA_WRITE_OUT(16), .DEPTH_UNITS(32)) bn ();
   sync_width_conv_fifo_if #(.DATA_WRITE_IN(16), .DATA_WRITE_OUT(64), .DEPTH_UNITS(32)) bw ();

   sync_width_conv_fifo #(.DATA_WRITE_IN(64), .DATA_WRITE_OUT(16), .DEPTH_UNITS(32), .AF_LEVEL(28))
      dut_n (.clk(clk), .rst(rst), .bus(bn.slave));
   sync_width_conv_fifo #(.DATA_WRITE_IN(16), .DATA_WRITE_OUT(64), .DEPTH_UNITS(32), .AF_LEVEL(28))
      dut_w (.clk(clk), .rst(rst), .bus(bw.slave));

   int total = 0;
   int bad   = 0;

   // Reference model: stored units in arrival order, plus last Q and sticky flags
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   logic [63:0] q_m   [2];
   bit          qv_m  [2];
   bit          ovf_m [2];
   bit          udf_m [2];

   function automatic int msize(input int k);
      return (k == 0) ? mq0.size() : mq1.size();
   endfunction
   function automatic int wu(input int k);
      return (k == 0) ? 4 : 1;
   endfunction
   function automatic int ru(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq0.delete();
      mq1.delete();
      for (int k = 0; k < 2; k++) begin
         q_m[k] = '0; qv_m[k] = 1'b0; ovf_m[k] = 1'b0; udf_m[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k, input bit we, input logic [63:0] wd, input bit re);
      int  sz;
      bit  wacc;
      bit  racc;
      logic [63:0] v;
      logic [15:0] u;
      sz   = msize(k);
      wacc = we && ((32 - sz) >= wu(k));
      racc = re && (sz >= ru(k));
      if (we && !wacc) ovf_m[k] = 1'b1;
      if (re && !racc) udf_m[k] = 1'b1;
      qv_m[k] = racc;
      if (racc) begin
         v = '0;
         for (int i = 0; i < ru(k); i++) begin
            u = (k == 0) ? mq0.pop_front() : mq1.pop_front();
            v = v | (64'(u) << (16 * i));
         end
         q_m[k] = v;
      end
      if (wacc) begin
         for (int i = 0; i < wu(k); i++) begin
            if (k == 0) mq0.push_back(wd[16*i +: 16]);
            else        mq1.push_back(wd[16*i +: 16]);
         end
      end
   endtask

   task automatic check_dut(input string p, input int k, input logic [63:0] cnt, input logic e,
                            input logic f, input logic af, input logic qv, input logic [63:0] q,
                            input logic ov, input logic ud);
      int sz;
      sz = msize(k);
      check({p, "_count"}, cnt, 64'(sz));
      check({p, "_empty"}, 64'(e), 64'(sz < ru(k)));
      check({p, "_full"}, 64'(f), 64'((32 - sz) < wu(k)));
      check({p, "_almost_full"}, 64'(af), 64'(sz >= 28));
      check({p, "_q_valid"}, 64'(qv), 64'(qv_m[k]));
      check({p, "_q"}, q, q_m[k]);
      check({p, "_ovf"}, 64'(ov), 64'(ovf_m[k]));
      check({p, "_udf"}, 64'(ud), 64'(udf_m[k]));
   endtask

   // One clock: drive both buses, step past the edge, update model, compare everything
   task automatic cyc(input bit we0, input logic [63:0] d0, input bit re0,
                      input bit we1, input logic [15:0] d1, input bit re1);
      bn.wr_en = we0; bn.d = d0; bn.rd_en = re0;
      bw.wr_en = we1; bw.d = d1; bw.rd_en = re1;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
      end else begin
         model_step(0, we0, d0, re0);
         model_step(1, we1, 64'(d1), re1);
      end
      check_dut("n", 0, 64'(bn.count), bn.empty, bn.full, bn.almost_full, bn.q_valid,
                64'(bn.q), bn.ovf, bn.udf);
      check_dut("w", 1, 64'(bw.count), bw.empty, bw.full, bw.almost_full, bw.q_valid,
                bw.q, bw.ovf, bw.udf);
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      logic [15:0] exp4 [4];
      logic [15:0] b;
      rst = 1'b1;
      bn.wr_en = 1'b0; bn.d = '0; bn.rd_en = 1'b0;
      bw.wr_en = 1'b0; bw.d = '0; bw.rd_en = 1'b0;

      // Reset state
      reset_cycle();
      check("rst_n_q", 64'(bn.q), 64'h0);
      check("rst_n_empty", 64'(bn.empty), 64'h1);

      // Narrowing little-endian split
      exp4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      cyc(1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b0, '0, 1'b0);
      check("narrow_count_after_wr", 64'(bn.count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
         check("narrow_q", 64'(bn.q), 64'(exp4[i]));
         check("narrow_q_valid", 64'(bn.q_valid), 64'h1);
      end
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
      check("narrow_drained_empty", 64'(bn.empty), 64'h1);
      check("narrow_q_valid_pulse", 64'(bn.q_valid), 64'h0);

      // Widening: partial word stays hidden until complete
      cyc(1'b0, '0, 1'b0, 1'b1, 16'hAAAA, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 16'hBBBB, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 16'hCCCC, 1'b0);
      check("wide_partial_empty", 64'(bw.empty), 64'h1);
      check("wide_partial_count", 64'(bw.count), 64'd3);
      cyc(1'b0, '0, 1'b0, 1'b1, 16'hDDDD, 1'b0);
      check("wide_complete_empty", 64'(bw.empty), 64'h0);
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      check("wide_q", bw.q, 64'hDDDD_CCCC_BBBB_AAAA);

      // Fill narrowing side, overflow attempt, drain
      for (int i = 0; i < 8; i++)
         cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, '0, 1'b0);
      check("fill_count", 64'(bn.count), 64'd32);
      check("fill_full", 64'(bn.full), 64'h1);
      check("fill_af", 64'(bn.almost_full), 64'h1);
      cyc(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b0, '0, 1'b0);
      check("ovf_set", 64'(bn.ovf), 64'h1);
      check("ovf_count_held", 64'(bn.count), 64'd32);
      for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      reset_cycle();

      // Simultaneous read+write at count 28
      for (int i = 0; i < 7; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, '0, 1'b0);
      check("c28_count", 64'(bn.count), 64'd28);
      cyc(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, '0, 1'b0);
      check("c28_both_count", 64'(bn.count), 64'd31);
      check("c28_both_full", 64'(bn.full), 64'h1);
      reset_cycle();

      // Wrap-around with incrementing data on both instances
      for (int r = 0; r < 20; r++) begin
         b = 16'(r * 4);
         cyc(1'b1, {b + 16'd3, b + 16'd2, b + 16'd1, b}, 1'b0, 1'b1, b, 1'b0);
         for (int i = 1; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b1, b + 16'(i), 1'b0);
            check("wrap_n_q", 64'(bn.q), 64'(b + 16'(i - 1)));
         end
         cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
         check("wrap_n_q_last", 64'(bn.q), 64'(b + 16'd3));
         check("wrap_w_q", bw.q, {b + 16'd3, b + 16'd2, b + 16'd1, b});
      end
      check("wrap_n_ovf", 64'(bn.ovf), 64'h0);
      check("wrap_n_udf", 64'(bn.udf), 64'h0);
      check("wrap_w_ovf", 64'(bw.ovf), 64'h0);
      check("wrap_w_udf", 64'(bw.udf), 64'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++)
         cyc(1'($urandom), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             16'($urandom), 1'($urandom_range(0, 3) == 0));

      // Reset during traffic: count 12 with a read being requested in the reset cycle
      reset_cycle();
      for (int i = 0; i < 4; i++)
         cyc(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 16'($urandom), 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b0, '0, 1'b1, 1'b1, 16'($urandom), 1'b0);
      check("pre_rst_count", 64'(bn.count), 64'd12);
      rst = 1'b1;
      cyc(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 16'($urandom), 1'b1);
      rst = 1'b0;
      check("rst_mid_count", 64'(bn.count), 64'd0);
      check("rst_mid_empty", 64'(bn.empty), 64'h1);
      check("rst_mid_q_valid", 64'(bn.q_valid), 64'h0);
      check("rst_mid_q", 64'(bn.q), 64'h0);
      check("rst_mid_w_q", bw.q, 64'h0);
      check("rst_mid_w_count", 64'(bw.count), 64'd0);
      cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
